// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: line requests to instcache, per-word filtering of
// empty/jump/halt words, and a valid/ready fetch queue of {inst, pc} entries.
module fetch_queue_unit #(
    parameter int unsigned       WORD_SIZE  = 32,
    parameter int unsigned       LINE_WORDS = 32,
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       FQ_DEPTH   = 4,
    parameter logic [ADDR_W-1:0] PC_RESET   = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    output logic                             ic_req,
    output logic [ADDR_W-1:0]                ic_addr,
    input  logic                             ic_valid,
    input  logic [WORD_SIZE*LINE_WORDS-1:0]  ic_line,
    input  logic                             redirect,
    input  logic [ADDR_W-1:0]                redirect_pc,
    output logic                             iq_valid,
    output logic [WORD_SIZE-1:0]             iq_inst,
    output logic [ADDR_W-1:0]                iq_pc,
    input  logic                             iq_ready,
    output logic                             halted
);

    localparam int unsigned WB     = WORD_SIZE / 8;
    localparam int unsigned LB     = LINE_WORDS * WB;
    localparam int unsigned WB_LSB = $clog2(WB);
    localparam int unsigned IDX_W  = $clog2(LINE_WORDS);
    localparam int unsigned PTR_W  = $clog2(FQ_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(WB - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LB - 1);

    localparam logic [3:0] OP_EMPTY = 4'b0000;
    localparam logic [3:0] OP_HALT  = 4'b0001;
    localparam logic [3:0] OP_JUMP  = 4'b1110;

    typedef enum logic [1:0] {
        RST_WAIT,
        REQ,
        STREAM,
        HALT
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    fetch_pc, pc_d;
    logic                 halted_q, halted_d;
    logic [WORD_SIZE-1:0] line_q [LINE_WORDS];

    logic [WORD_SIZE-1:0] inst_mem [FQ_DEPTH];
    logic [ADDR_W-1:0]    pc_mem   [FQ_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count_q;

    logic [IDX_W-1:0]     widx;
    logic [WORD_SIZE-1:0] cur_word;
    logic [3:0]           opcode;
    logic [ADDR_W-1:0]    jump_pc;
    logic                 last_word;
    logic                 load_line, push, pop, advance, has_space;

    // The word index is the word offset of fetch_pc, which advances in lockstep.
    assign widx      = fetch_pc[WB_LSB +: IDX_W];
    assign cur_word  = line_q[widx];
    assign opcode    = cur_word[WORD_SIZE-1 -: 4];
    assign jump_pc   = ADDR_W'(cur_word[27:0]) & WORD_MASK;
    assign last_word = (widx == '1);

    assign iq_valid  = (count_q != '0) && !redirect;
    assign pop       = iq_valid && iq_ready;
    assign has_space = (count_q != CNT_W'(FQ_DEPTH)) || pop;

    assign ic_req    = (state_q == REQ);
    assign ic_addr   = ic_req ? (fetch_pc & LINE_MASK) : '0;
    assign iq_inst   = (count_q != '0) ? inst_mem[rd_ptr] : '0;
    assign iq_pc     = (count_q != '0) ? pc_mem[rd_ptr] : '0;
    assign halted    = halted_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = fetch_pc;
        halted_d  = halted_q;
        load_line = 1'b0;
        push      = 1'b0;
        advance   = 1'b0;
        if (redirect) begin
            state_d  = REQ;
            pc_d     = redirect_pc & WORD_MASK;
            halted_d = 1'b0;
        end else begin
            case (state_q)
                RST_WAIT: state_d = REQ;
                REQ: begin
                    if (ic_valid) begin
                        load_line = 1'b1;
                        state_d   = STREAM;
                    end
                end
                STREAM: begin
                    if (has_space) begin
                        case (opcode)
                            OP_EMPTY: advance = 1'b1;
                            OP_JUMP: begin
                                pc_d    = jump_pc;
                                state_d = REQ;
                            end
                            OP_HALT: begin
                                push     = 1'b1;
                                state_d  = HALT;
                                halted_d = 1'b1;
                            end
                            default: begin
                                push    = 1'b1;
                                advance = 1'b1;
                            end
                        endcase
                        if (advance) begin
                            pc_d = fetch_pc + ADDR_W'(WB);
                            if (last_word) state_d = REQ;
                        end
                    end
                end
                HALT:    state_d = HALT;
                default: state_d = RST_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RST_WAIT;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= PC_RESET & WORD_MASK;
            halted_q <= 1'b0;
            count_q  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            fetch_pc <= pc_d;
            halted_q <= halted_d;
            if (redirect) begin
                count_q <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
            end else begin
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_line) begin
            for (int unsigned k = 0; k < LINE_WORDS; k++) begin
                line_q[k] <= ic_line[(LINE_WORDS-1-k)*WORD_SIZE +: WORD_SIZE];
            end
        end
        if (push) begin
            inst_mem[wr_ptr] <= cur_word;
            pc_mem[wr_ptr]   <= fetch_pc;
        end
    end

endmodule
